// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU issue queue with CDB wakeup and age-ordered select

package alu_rs_pkg;
    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       is_branch;
    } control_t;
endpackage

module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int RS_DEPTH        = 4,
    parameter int REG_VAL_WIDTH   = 32,
    parameter int PHYS_REG_WIDTH  = 6,
    parameter int ROB_TAG_WIDTH   = 5,
    parameter int INST_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PHYS_REG_WIDTH-1:0]  disp_src1_tag,
    input  logic [PHYS_REG_WIDTH-1:0]  disp_src2_tag,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [REG_VAL_WIDTH-1:0]   disp_src1_val,
    input  logic [REG_VAL_WIDTH-1:0]   disp_src2_val,
    input  logic [PHYS_REG_WIDTH-1:0]  disp_dst_reg_addr,
    input  control_t                   disp_control,
    input  logic [REG_VAL_WIDTH-1:0]   disp_immediate,
    input  logic [INST_ADDR_WIDTH-1:0] disp_pc,
    input  logic [ROB_TAG_WIDTH-1:0]   disp_inst_tag,
    input  logic                       cdb_valid,
    input  logic [PHYS_REG_WIDTH-1:0]  cdb_addr,
    input  logic [REG_VAL_WIDTH-1:0]   cdb_val,
    input  logic                       alu_ready,
    output logic                       rs_valid,
    output logic [REG_VAL_WIDTH-1:0]   src_reg1_val,
    output logic [REG_VAL_WIDTH-1:0]   src_reg2_val,
    output logic [PHYS_REG_WIDTH-1:0]  dst_reg_addr,
    output control_t                   control,
    output logic [REG_VAL_WIDTH-1:0]   immediate,
    output logic [INST_ADDR_WIDTH-1:0] pc_in,
    output logic [ROB_TAG_WIDTH-1:0]   new_inst_tag_in,
    output logic [$clog2(RS_DEPTH):0]  free_count
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = IW + 1;

    // Entry storage
    logic [RS_DEPTH-1:0]        valid_q;
    logic [RS_DEPTH-1:0]        s1_rdy_q;
    logic [RS_DEPTH-1:0]        s2_rdy_q;
    logic [PHYS_REG_WIDTH-1:0]  s1_tag_q [RS_DEPTH];
    logic [PHYS_REG_WIDTH-1:0]  s2_tag_q [RS_DEPTH];
    logic [REG_VAL_WIDTH-1:0]   s1_val_q [RS_DEPTH];
    logic [REG_VAL_WIDTH-1:0]   s2_val_q [RS_DEPTH];
    logic [PHYS_REG_WIDTH-1:0]  dst_q    [RS_DEPTH];
    control_t                   ctrl_q   [RS_DEPTH];
    logic [REG_VAL_WIDTH-1:0]   imm_q    [RS_DEPTH];
    logic [INST_ADDR_WIDTH-1:0] pc_q     [RS_DEPTH];
    logic [ROB_TAG_WIDTH-1:0]   itag_q   [RS_DEPTH];

    // older_q[i][j] = 1 means entry j is older than entry i
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;

    // Issue register
    logic                       rs_valid_q;
    logic [REG_VAL_WIDTH-1:0]   src_reg1_val_q, src_reg2_val_q, immediate_q;
    logic [PHYS_REG_WIDTH-1:0]  dst_reg_addr_q;
    control_t                   control_q;
    logic [INST_ADDR_WIDTH-1:0] pc_in_q;
    logic [ROB_TAG_WIDTH-1:0]   new_inst_tag_in_q;

    logic [RS_DEPTH-1:0] eligible, issue_oh, issue_clr, disp_oh;
    logic [IW-1:0]       issue_idx;
    logic [CW-1:0]       free_cnt;
    logic                issue_fire, disp_fire;
    logic                disp1_rdy, disp2_rdy;
    logic [REG_VAL_WIDTH-1:0] disp1_val, disp2_val;

    // Pick the eligible entry that has no older eligible entry
    always_comb begin
        eligible  = valid_q & s1_rdy_q & s2_rdy_q;
        issue_oh  = '0;
        issue_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (eligible[i] && ((older_q[i] & eligible) == '0)) begin
                issue_oh[i] = 1'b1;
                issue_idx   = IW'(i);
            end
        end
    end

    // Lowest free slot for dispatch and the count of free slots
    always_comb begin
        disp_oh  = '0;
        free_cnt = CW'(RS_DEPTH);
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                disp_oh    = '0;
                disp_oh[i] = 1'b1;
            end else begin
                free_cnt = free_cnt - 1'b1;
            end
        end
    end

    assign free_count = free_cnt;
    assign disp_ready = (free_cnt != '0);
    assign disp_fire  = disp_valid && disp_ready && !flush;
    // Uses only registered rs_valid_q, so no combinational path alu_ready -> rs_valid
    assign issue_fire = alu_ready && !rs_valid_q && (|eligible) && !flush;
    assign issue_clr  = issue_fire ? issue_oh : '0;

    // Same-cycle CDB bypass for operands arriving with dispatch
    assign disp1_rdy = disp_src1_rdy || (cdb_valid && (disp_src1_tag == cdb_addr));
    assign disp2_rdy = disp_src2_rdy || (cdb_valid && (disp_src2_tag == cdb_addr));
    assign disp1_val = disp_src1_rdy ? disp_src1_val : cdb_val;
    assign disp2_val = disp_src2_rdy ? disp_src2_val : cdb_val;

    // Age matrix next state: freed column cleared, new row marks all survivors older
    always_comb begin
        older_d = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            older_d[i] = older_q[i] & ~issue_clr;
            if (disp_fire && disp_oh[i]) begin
                older_d[i] = valid_q & ~issue_clr;
            end
        end
    end

    // Entry state: free on issue, capture CDB wakeups, write dispatched entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            older_q  <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
                dst_q[i]    <= '0;
                ctrl_q[i]   <= '0;
                imm_q[i]    <= '0;
                pc_q[i]     <= '0;
                itag_q[i]   <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            older_q <= '0;
        end else begin
            older_q <= older_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (issue_clr[i]) begin
                    valid_q[i] <= 1'b0;
                end
                if (cdb_valid && valid_q[i] && !s1_rdy_q[i] && (s1_tag_q[i] == cdb_addr)) begin
                    s1_rdy_q[i] <= 1'b1;
                    s1_val_q[i] <= cdb_val;
                end
                if (cdb_valid && valid_q[i] && !s2_rdy_q[i] && (s2_tag_q[i] == cdb_addr)) begin
                    s2_rdy_q[i] <= 1'b1;
                    s2_val_q[i] <= cdb_val;
                end
                if (disp_fire && disp_oh[i]) begin
                    valid_q[i]  <= 1'b1;
                    s1_rdy_q[i] <= disp1_rdy;
                    s2_rdy_q[i] <= disp2_rdy;
                    s1_tag_q[i] <= disp_src1_tag;
                    s2_tag_q[i] <= disp_src2_tag;
                    s1_val_q[i] <= disp1_val;
                    s2_val_q[i] <= disp2_val;
                    dst_q[i]    <= disp_dst_reg_addr;
                    ctrl_q[i]   <= disp_control;
                    imm_q[i]    <= disp_immediate;
                    pc_q[i]     <= disp_pc;
                    itag_q[i]   <= disp_inst_tag;
                end
            end
        end
    end

    // Issue register: one-cycle rs_valid pulse, payload held between issues
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_valid_q        <= 1'b0;
            src_reg1_val_q    <= '0;
            src_reg2_val_q    <= '0;
            dst_reg_addr_q    <= '0;
            control_q         <= '0;
            immediate_q       <= '0;
            pc_in_q           <= '0;
            new_inst_tag_in_q <= '0;
        end else if (issue_fire) begin
            rs_valid_q        <= 1'b1;
            src_reg1_val_q    <= s1_val_q[issue_idx];
            src_reg2_val_q    <= s2_val_q[issue_idx];
            dst_reg_addr_q    <= dst_q[issue_idx];
            control_q         <= ctrl_q[issue_idx];
            immediate_q       <= imm_q[issue_idx];
            pc_in_q           <= pc_q[issue_idx];
            new_inst_tag_in_q <= itag_q[issue_idx];
        end else begin
            rs_valid_q <= 1'b0;
        end
    end

    assign rs_valid        = rs_valid_q;
    assign src_reg1_val    = src_reg1_val_q;
    assign src_reg2_val    = src_reg2_val_q;
    assign dst_reg_addr    = dst_reg_addr_q;
    assign control         = control_q;
    assign immediate       = immediate_q;
    assign pc_in           = pc_in_q;
    assign new_inst_tag_in = new_inst_tag_in_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - randomized model-checked bench for alu_reservation_station

module tb_alu_reservation_station;
    import alu_rs_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, disp_valid, disp_ready;
    logic [5:0]  disp_src1_tag, disp_src2_tag, disp_dst_reg_addr;
    logic        disp_src1_rdy, disp_src2_rdy;
    logic [31:0] disp_src1_val, disp_src2_val, disp_immediate, disp_pc;
    control_t    disp_control;
    logic [4:0]  disp_inst_tag;
    logic        cdb_valid;
    logic [5:0]  cdb_addr;
    logic [31:0] cdb_val;
    logic        alu_ready, rs_valid;
    logic [31:0] src_reg1_val, src_reg2_val, immediate, pc_in;
    logic [5:0]  dst_reg_addr;
    control_t    control;
    logic [4:0]  new_inst_tag_in;
    logic [2:0]  free_count;

    alu_reservation_station dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_dst_reg_addr(disp_dst_reg_addr), .disp_control(disp_control),
        .disp_immediate(disp_immediate), .disp_pc(disp_pc), .disp_inst_tag(disp_inst_tag),
        .cdb_valid(cdb_valid), .cdb_addr(cdb_addr), .cdb_val(cdb_val),
        .alu_ready(alu_ready), .rs_valid(rs_valid),
        .src_reg1_val(src_reg1_val), .src_reg2_val(src_reg2_val),
        .dst_reg_addr(dst_reg_addr), .control(control), .immediate(immediate),
        .pc_in(pc_in), .new_inst_tag_in(new_inst_tag_in), .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] v1, v2, imm, pc;
        logic [5:0]  t1, t2, dst;
        logic        r1, r2;
        control_t    ctl;
        logic [4:0]  itag;
    } ent_t;

    ent_t q[$];
    ent_t m_out;
    logic m_rs_valid;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rs_valid = 1'b0;
        m_out      = '0;
    endtask

    // Queue order is age order: front is oldest
    task automatic model_edge();
        int   sel;
        bit   acc;
        ent_t e, w;
        if (flush) begin
            q.delete();
            m_rs_valid = 1'b0;
            return;
        end
        sel = -1;
        if (alu_ready && !m_rs_valid)
            for (int i = 0; i < q.size(); i++)
                if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
        acc = disp_valid && (q.size() < DEPTH);
        e.r1   = disp_src1_rdy || (cdb_valid && disp_src1_tag == cdb_addr);
        e.r2   = disp_src2_rdy || (cdb_valid && disp_src2_tag == cdb_addr);
        e.v1   = disp_src1_rdy ? disp_src1_val : cdb_val;
        e.v2   = disp_src2_rdy ? disp_src2_val : cdb_val;
        e.t1   = disp_src1_tag;
        e.t2   = disp_src2_tag;
        e.dst  = disp_dst_reg_addr;
        e.ctl  = disp_control;
        e.imm  = disp_immediate;
        e.pc   = disp_pc;
        e.itag = disp_inst_tag;
        for (int i = 0; i < q.size(); i++) begin
            w = q[i];
            if (cdb_valid && !w.r1 && w.t1 == cdb_addr) begin w.r1 = 1'b1; w.v1 = cdb_val; end
            if (cdb_valid && !w.r2 && w.t2 == cdb_addr) begin w.r2 = 1'b1; w.v2 = cdb_val; end
            q[i] = w;
        end
        if (sel >= 0) begin
            m_rs_valid = 1'b1;
            m_out      = q[sel];
            q.delete(sel);
        end else begin
            m_rs_valid = 1'b0;
        end
        if (acc) q.push_back(e);
    endtask

    task automatic compare();
        check("rs_valid", 64'(rs_valid), 64'(m_rs_valid));
        check("free_count", 64'(free_count), 64'(DEPTH - q.size()));
        check("disp_ready", 64'(disp_ready), 64'(q.size() < DEPTH));
        check("src1", 64'(src_reg1_val), 64'(m_out.v1));
        check("src2", 64'(src_reg2_val), 64'(m_out.v2));
        check("dst", 64'(dst_reg_addr), 64'(m_out.dst));
        check("ctrl", 64'(control), 64'(m_out.ctl));
        check("imm", 64'(immediate), 64'(m_out.imm));
        check("pc", 64'(pc_in), 64'(m_out.pc));
        check("itag", 64'(new_inst_tag_in), 64'(m_out.itag));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        compare();
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                            input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                            input logic [5:0] dst, input logic [4:0] itag);
        logic [5:0] c;
        c = 6'($urandom);
        disp_valid        = 1'b1;
        disp_src1_tag     = t1;
        disp_src1_rdy     = r1;
        disp_src1_val     = v1;
        disp_src2_tag     = t2;
        disp_src2_rdy     = r2;
        disp_src2_val     = v2;
        disp_dst_reg_addr = dst;
        disp_inst_tag     = itag;
        disp_control      = c;
        disp_immediate    = $urandom;
        disp_pc           = $urandom;
    endtask

    task automatic cdb(input logic [5:0] a, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_addr  = a;
        cdb_val   = v;
    endtask

    initial begin
        int exp_tag;
        reset = 1'b1;
        idle();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        cdb_addr = '0;
        cdb_val  = '0;
        alu_ready = 1'b1;
        model_reset();
        step();
        step();
        reset = 1'b0;
        check("reset_free", 64'(free_count), 64'(4));
        check("reset_rdy", 64'(disp_ready), 64'(1));
        check("reset_rsv", 64'(rs_valid), 64'(0));

        // Both sources ready: issue one cycle after dispatch
        set_disp(0, 1, 5, 0, 1, 7, 10, 3);
        step();
        idle();
        step();
        check("t1_rsv", 64'(rs_valid), 64'(1));
        check("t1_src1", 64'(src_reg1_val), 64'(5));
        check("t1_src2", 64'(src_reg2_val), 64'(7));
        check("t1_dst", 64'(dst_reg_addr), 64'(10));
        check("t1_tag", 64'(new_inst_tag_in), 64'(3));
        step();
        check("t1_pulse", 64'(rs_valid), 64'(0));
        check("t1_free", 64'(free_count), 64'(4));

        // Wakeup via CDB two cycles after dispatch
        set_disp(12, 0, 0, 0, 1, 1, 11, 4);
        step();
        idle();
        step();
        cdb(12, 32'h55);
        step();
        idle();
        check("t2_early", 64'(rs_valid), 64'(0));
        step();
        check("t2_rsv", 64'(rs_valid), 64'(1));
        check("t2_src1", 64'(src_reg1_val), 64'(32'h55));
        step();

        // Same-cycle bypass at dispatch
        set_disp(9, 0, 0, 0, 1, 2, 12, 5);
        cdb(9, 32'hAA);
        step();
        idle();
        step();
        check("t3_rsv", 64'(rs_valid), 64'(1));
        check("t3_src1", 64'(src_reg1_val), 64'(32'hAA));
        step();

        // Fill all entries, over-dispatch, then release in age order
        for (int i = 0; i < 4; i++) begin
            set_disp(20, 0, 0, 0, 1, i, 6'(i), 5'(i));
            step();
        end
        check("t4_full_free", 64'(free_count), 64'(0));
        check("t4_full_rdy", 64'(disp_ready), 64'(0));
        set_disp(0, 1, 1, 0, 1, 1, 7, 9);
        step();
        idle();
        cdb(20, 32'h1234);
        step();
        idle();
        exp_tag = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rs_valid) begin
                check("t4_order", 64'(new_inst_tag_in), 64'(exp_tag));
                exp_tag++;
            end
        end
        check("t4_count", 64'(exp_tag), 64'(4));

        // Younger ready entry overtakes a waiting older one
        set_disp(7, 0, 0, 0, 1, 3, 13, 5);
        step();
        set_disp(0, 1, 8, 0, 1, 9, 14, 6);
        step();
        idle();
        step();
        check("t5_b_first", 64'(new_inst_tag_in), 64'(6));
        alu_ready = 1'b0;
        cdb(7, 32'h77);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_hold", 64'(rs_valid), 64'(0));
        end
        alu_ready = 1'b1;
        step();
        check("t5_a_tag", 64'(new_inst_tag_in), 64'(5));
        step();

        // Flush on the cycle an issue would launch
        alu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(0, 1, i, 0, 1, i, 6'(i), 5'(i + 16));
            step();
        end
        idle();
        alu_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_rsv", 64'(rs_valid), 64'(0));
        check("t6_free", 64'(free_count), 64'(4));
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_issue", 64'(rs_valid), 64'(0));
        end

        // Async reset while rs_valid is high
        set_disp(0, 1, 32'hDEAD, 0, 1, 32'hBEEF, 21, 7);
        step();
        idle();
        step();
        check("t7_pre", 64'(rs_valid), 64'(1));
        reset = 1'b1;
        #1;
        check("t7_rsv", 64'(rs_valid), 64'(0));
        check("t7_src1", 64'(src_reg1_val), 64'(0));
        check("t7_tag", 64'(new_inst_tag_in), 64'(0));
        model_reset();
        step();
        reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 1) == 1)
                set_disp(6'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0), $urandom,
                         6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                         6'($urandom), 5'($urandom));
            else
                disp_valid = 1'b0;
            cdb_valid = ($urandom_range(0, 9) < 4);
            cdb_addr  = 6'($urandom_range(0, 7));
            cdb_val   = $urandom;
            alu_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
